// File: rtl/rv32i_types.sv
// Shared cache geometry: line width, tag/set/offset split and line-address build.
package rv32i_types;

  localparam int LINE_W   = 256;
  localparam int TAG_W    = 24;
  localparam int SET_W    = 3;
  localparam int OFFSET_W = 5;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [SET_W-1:0]  set_t;

  function automatic tag_t addr_tag(input logic [31:0] addr);
    return addr[31 -: TAG_W];
  endfunction

  function automatic set_t addr_set(input logic [31:0] addr);
    return addr[OFFSET_W +: SET_W];
  endfunction

  function automatic logic [31:0] line_addr(input tag_t tag, input set_t set);
    return {tag, set, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/pipelined_cache_line_buf.sv
// One cache line of storage with load enable and asynchronous active-low clear.
module pipelined_cache_line_buf
  import rv32i_types::*;
(
  input  logic  i_clk,
  input  logic  i_clr_n,
  input  logic  i_load,
  input  line_t i_d,
  output line_t o_q
);

  line_t r_line;

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_line <= '0;
    end else if (i_load) begin
      r_line <= i_d;
    end
  end

  assign o_q = r_line;

endmodule

// File: rtl/pipelined_cache_miss_ctrl.sv
// Miss handler for the pipelined cache: stalls the pipe, writes back a dirty
// victim, fetches the missing line and installs it for the replayed lookup.
module pipelined_cache_miss_ctrl
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_address,
  input  logic        hit,
  input  logic        dirty,
  input  logic        lru,
  input  tag_t        victim_tag,
  input  line_t       victim_data,
  input  line_t       pmem_rdata,
  input  logic        pmem_resp,
  output logic        stall,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output line_t       pmem_wdata,
  output logic        fill_load,
  output logic        fill_way,
  output set_t        fill_set,
  output tag_t        fill_tag,
  output line_t       fill_data,
  output logic [15:0] miss_count,
  output logic [15:0] wb_count
);

  // state   | meaning
  // IDLE    | no miss in flight; watching stage-2 lookups
  // WB      | writing the dirty victim line back to memory
  // FILL    | reading the missing line from memory
  // INSTALL | single cycle writing the fetched line into the arrays
  typedef enum logic [1:0] {IDLE, WB, FILL, INSTALL} state_t;

  state_t      r_state;
  state_t      w_next;
  tag_t        r_tag;
  set_t        r_set;
  logic        r_lru;
  tag_t        r_victim_tag;
  logic [15:0] r_miss_count;
  logic [15:0] r_wb_count;
  logic        w_miss;
  logic        w_wb_done;
  logic        w_fill_done;
  line_t       w_victim_line;
  line_t       w_fill_line;
  logic        w_offset_unused;

  assign w_offset_unused = ^req_address[OFFSET_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_miss       = 1'b0;
    w_wb_done    = 1'b0;
    w_fill_done  = 1'b0;
    stall        = 1'b1;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    fill_load    = 1'b0;
    case (r_state)
      IDLE: begin
        // Stall rises combinationally so the stage registers freeze on the miss cycle.
        stall = req_valid && !hit;
        if (req_valid && !hit) begin
          w_miss = 1'b1;
          w_next = dirty ? WB : FILL;
        end
      end
      WB: begin
        pmem_write   = 1'b1;
        pmem_address = line_addr(r_victim_tag, r_set);
        if (pmem_resp) begin
          w_wb_done = 1'b1;
          w_next    = FILL;
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = line_addr(r_tag, r_set);
        if (pmem_resp) begin
          w_fill_done = 1'b1;
          w_next      = INSTALL;
        end
      end
      INSTALL: begin
        fill_load = 1'b1;
        w_next    = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag        <= '0;
      r_set        <= '0;
      r_lru        <= 1'b0;
      r_victim_tag <= '0;
    end else if (w_miss) begin
      r_tag        <= addr_tag(req_address);
      r_set        <= addr_set(req_address);
      r_lru        <= lru;
      r_victim_tag <= victim_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_miss_count <= '0;
      r_wb_count   <= '0;
    end else begin
      if (w_miss && (r_miss_count != 16'hFFFF)) begin
        r_miss_count <= r_miss_count + 16'd1;
      end
      if (w_wb_done && (r_wb_count != 16'hFFFF)) begin
        r_wb_count <= r_wb_count + 16'd1;
      end
    end
  end

  pipelined_cache_line_buf u_victim_buf (
    .i_clk   (clk),
    .i_clr_n (rst),
    .i_load  (w_miss),
    .i_d     (victim_data),
    .o_q     (w_victim_line)
  );

  pipelined_cache_line_buf u_fill_buf (
    .i_clk   (clk),
    .i_clr_n (rst),
    .i_load  (w_fill_done),
    .i_d     (pmem_rdata),
    .o_q     (w_fill_line)
  );

  assign pmem_wdata = w_victim_line;
  assign fill_way   = r_lru;
  assign fill_set   = r_set;
  assign fill_tag   = r_tag;
  assign fill_data  = w_fill_line;
  assign miss_count = r_miss_count;
  assign wb_count   = r_wb_count;

endmodule

// File: tb/tb_pipelined_cache_miss_ctrl.sv
// Scoreboard bench for the cache miss controller: expected memory/fill events
// are queued per miss and compared when the controller produces them.
module tb_pipelined_cache_miss_ctrl;

  localparam int K_WR   = 0;
  localparam int K_RD   = 1;
  localparam int K_FILL = 2;

  typedef struct {
    int           kind;
    logic [31:0]  addr;
    logic [255:0] data;
    logic         way;
    logic [2:0]   set;
    logic [23:0]  tag;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic [31:0]  req_address;
  logic         hit;
  logic         dirty;
  logic         lru;
  logic [23:0]  victim_tag;
  logic [255:0] victim_data;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         stall;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         fill_load;
  logic         fill_way;
  logic [2:0]   fill_set;
  logic [23:0]  fill_tag;
  logic [255:0] fill_data;
  logic [15:0]  miss_count;
  logic [15:0]  wb_count;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  int          wb_lat = 1;
  int          rd_lat = 1;
  bit          stray = 1'b0;
  logic [15:0] exp_miss = '0;
  logic [15:0] exp_wb = '0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_rd_addr = '0;
  logic        last_fill_way = 1'b0;
  logic [2:0]  last_fill_set = '0;
  logic [23:0] last_fill_tag = '0;
  int          fill_pulses = 0;

  pipelined_cache_miss_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_address  (req_address),
    .hit          (hit),
    .dirty        (dirty),
    .lru          (lru),
    .victim_tag   (victim_tag),
    .victim_data  (victim_data),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .stall        (stall),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .fill_load    (fill_load),
    .fill_way     (fill_way),
    .fill_set     (fill_set),
    .fill_tag     (fill_tag),
    .fill_data    (fill_data),
    .miss_count   (miss_count),
    .wb_count     (wb_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] la(input logic [23:0] t, input logic [2:0] s);
    return {t, s, 5'b00000};
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    return {8{a ^ 32'hC0DE_5A5A}};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Memory model: responds after the programmed number of strobe cycles.
  initial begin
    int cnt;
    cnt = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cnt = 0;
        pmem_resp = 1'b0;
      end else if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt == (pmem_read ? rd_lat : wb_lat)) begin
          pmem_resp = 1'b1;
          cnt = 0;
          pmem_rdata = pmem_read ? mem_line(pmem_address) : {8{$urandom}};
        end else begin
          pmem_resp = 1'b0;
          pmem_rdata = {8{$urandom}};
        end
      end else begin
        cnt = 0;
        pmem_resp = stray;
        pmem_rdata = {8{$urandom}};
      end
    end
  end

  // Monitor: pops the scoreboard on each rising strobe and on each fill pulse.
  initial begin
    bit   prev_r, prev_w, prev_f;
    exp_t e;
    prev_r = 1'b0;
    prev_w = 1'b0;
    prev_f = 1'b0;
    forever begin
      @(negedge clk);
      if (pmem_write && !prev_w) begin
        if (sb.size() == 0) chk("sb_underflow_wr", sb.size(), 1);
        else begin
          e = sb.pop_front();
          last_wr_addr = pmem_address;
          chk("wr_order", K_WR, e.kind);
          chk("wr_addr", pmem_address, e.addr);
          chk("wr_data", pmem_wdata, e.data);
          chk("wr_excl", pmem_read, 1'b0);
        end
      end
      if (pmem_read && !prev_r) begin
        if (sb.size() == 0) chk("sb_underflow_rd", sb.size(), 1);
        else begin
          e = sb.pop_front();
          last_rd_addr = pmem_address;
          chk("rd_order", K_RD, e.kind);
          chk("rd_addr", pmem_address, e.addr);
          chk("rd_excl", pmem_write, 1'b0);
        end
      end
      if (fill_load) begin
        fill_pulses++;
        if (prev_f) chk("fill_one_cycle", prev_f, 1'b0);
        if (sb.size() == 0) chk("sb_underflow_fill", sb.size(), 1);
        else begin
          e = sb.pop_front();
          last_fill_way = fill_way;
          last_fill_set = fill_set;
          last_fill_tag = fill_tag;
          chk("fill_order", K_FILL, e.kind);
          chk("fill_way", fill_way, e.way);
          chk("fill_set", fill_set, e.set);
          chk("fill_tag", fill_tag, e.tag);
          chk("fill_data", fill_data, e.data);
        end
      end
      prev_r = pmem_read;
      prev_w = pmem_write;
      prev_f = fill_load;
    end
  end

  task automatic do_miss(input logic [31:0] addr, input bit d, input bit way,
                         input logic [23:0] vtag, input logic [255:0] vdata,
                         input int wl, input int rl);
    exp_t e;
    int   n;
    bit   done;
    wb_lat = wl;
    rd_lat = rl;
    if (d) begin
      e = '{kind: K_WR, addr: la(vtag, addr[7:5]), data: vdata, way: 1'b0, set: 3'd0, tag: 24'd0};
      sb.push_back(e);
      exp_wb = sat_inc(exp_wb);
    end
    e = '{kind: K_RD, addr: la(addr[31:8], addr[7:5]), data: '0, way: 1'b0, set: 3'd0, tag: 24'd0};
    sb.push_back(e);
    e = '{kind: K_FILL, addr: '0, data: mem_line(la(addr[31:8], addr[7:5])), way: way,
          set: addr[7:5], tag: addr[31:8]};
    sb.push_back(e);
    exp_miss = sat_inc(exp_miss);

    @(negedge clk);
    req_valid   = 1'b1;
    hit         = 1'b0;
    req_address = addr;
    dirty       = d;
    lru         = way;
    victim_tag  = vtag;
    victim_data = vdata;
    #1;
    chk("stall_rise", stall, 1'b1);
    n = 1;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 0) begin
        // Scramble the request side; the captured transaction must not notice.
        req_valid   = 1'b0;
        hit         = 1'($urandom);
        req_address = $urandom;
        dirty       = 1'($urandom);
        lru         = 1'($urandom);
        victim_tag  = 24'($urandom);
        victim_data = {8{$urandom}};
      end
      #1;
      if (!stall) begin
        done = 1'b1;
        break;
      end
      n++;
    end
    chk("miss_done", done, 1'b1);
    chk("stall_len", n, 2 + rl + (d ? wl : 0));
    chk("miss_count", miss_count, exp_miss);
    chk("wb_count", wb_count, exp_wb);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses_before;
    rst = 1'b0;
    req_valid = 1'b0;
    req_address = '0;
    hit = 1'b0;
    dirty = 1'b0;
    lru = 1'b0;
    victim_tag = '0;
    victim_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_fill_load", fill_load, 1'b0);
    chk("rst_miss_count", miss_count, 16'h0);
    chk("rst_wb_count", wb_count, 16'h0);
    chk("rst_pmem_addr_lsb", pmem_address[4:0], 5'h0);
    @(negedge clk);
    rst = 1'b1;

    // Hit: no stall, no memory traffic, counter untouched.
    @(negedge clk);
    req_valid = 1'b1;
    hit = 1'b1;
    req_address = 32'h0000_1234;
    #1;
    chk("hit_stall", stall, 1'b0);
    @(negedge clk);
    #1;
    chk("hit_no_read", pmem_read, 1'b0);
    chk("hit_no_write", pmem_write, 1'b0);
    chk("hit_miss_count", miss_count, 16'h0);
    req_valid = 1'b0;
    hit = 1'b0;

    // Clean miss.
    pulses_before = fill_pulses;
    do_miss(32'h0000_1234, 1'b0, 1'b0, 24'h111111, {8{32'h1111_2222}}, 1, 4);
    chk("clean_rd_addr", last_rd_addr, 32'h0000_1220);
    chk("clean_fill_set", last_fill_set, 3'd1);
    chk("clean_fill_tag", last_fill_tag, 24'h000012);
    chk("clean_fill_pulses", fill_pulses - pulses_before, 1);

    // Dirty miss into set 2, way 1.
    do_miss(32'h0000_5640, 1'b1, 1'b1, 24'hABCDEF, {8{32'hDEAD_BEEF}}, 3, 2);
    chk("dirty_wr_addr", last_wr_addr, 32'hABCD_EF40);
    chk("dirty_fill_way", last_fill_way, 1'b1);
    chk("dirty_wb_count", wb_count, 16'h1);

    for (int i = 0; i < 8; i++) begin
      do_miss($urandom, 1'($urandom), 1'($urandom), 24'($urandom), {8{$urandom}},
              $urandom_range(1, 5), $urandom_range(1, 5));
    end

    // Stray response while idle must be ignored.
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    @(negedge clk);
    stray = 1'b0;
    #1;
    chk("stray_stall", stall, 1'b0);
    chk("stray_no_read", pmem_read, 1'b0);
    chk("stray_no_write", pmem_write, 1'b0);
    chk("stray_no_fill", fill_load, 1'b0);
    chk("stray_miss_count", miss_count, exp_miss);

    // Reset in the middle of FILL.
    rd_lat = 1000;
    sb.push_back('{kind: K_RD, addr: la(24'h000077, 3'd3), data: '0, way: 1'b0, set: 3'd0, tag: 24'd0});
    @(negedge clk);
    req_valid = 1'b1;
    hit = 1'b0;
    dirty = 1'b0;
    req_address = 32'h0000_7760;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("midfill_read_high", pmem_read, 1'b1);
    rst = 1'b0;
    #1;
    chk("midfill_read_drop", pmem_read, 1'b0);
    chk("midfill_write", pmem_write, 1'b0);
    chk("midfill_stall", stall, 1'b0);
    chk("midfill_miss_count", miss_count, 16'h0);
    chk("midfill_wb_count", wb_count, 16'h0);
    sb.delete();
    exp_miss = '0;
    exp_wb = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("after_rst_idle", stall, 1'b0);
    chk("after_rst_fill", fill_load, 1'b0);

    // Saturation: preload counters near the top, then keep missing.
    @(negedge clk);
    force dut.r_miss_count = 16'hFFFE;
    force dut.r_wb_count = 16'hFFFF;
    #1;
    release dut.r_miss_count;
    release dut.r_wb_count;
    exp_miss = 16'hFFFE;
    exp_wb = 16'hFFFF;
    do_miss(32'h0000_0020, 1'b0, 1'b0, 24'h0, '0, 1, 1);
    chk("sat_miss_ffff", miss_count, 16'hFFFF);
    do_miss(32'h0000_0040, 1'b1, 1'b1, 24'h123456, {8{32'h0F0F_0F0F}}, 1, 1);
    chk("sat_miss_hold", miss_count, 16'hFFFF);
    chk("sat_wb_hold", wb_count, 16'hFFFF);

    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
